// File: rtl/rx_word_buffer.sv
// Receive framer: hunts for a sync word in the serial bit stream, then packs the
// following payload bits MSB-first into words offered on a valid/ready output.
module rx_word_buffer #(
    parameter int                WORD_W      = 16,
    parameter logic [WORD_W-1:0] SYNC_WORD   = 16'hEB90,
    parameter int                FRAME_WORDS = 8,
    localparam int               IDX_W       = (FRAME_WORDS > 1) ? $clog2(FRAME_WORDS) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              bit_in,
    input  logic              bit_valid,
    input  logic              out_ready,
    output logic [WORD_W-1:0] buff_out,
    output logic              word_valid,
    output logic [IDX_W-1:0]  word_idx,
    output logic              locked,
    output logic              frame_done,
    output logic              overrun,
    output logic [15:0]       sync_count
);

    localparam int               BIT_W     = $clog2(WORD_W);
    localparam logic [BIT_W-1:0] LAST_BIT  = BIT_W'(WORD_W - 1);
    localparam logic [IDX_W-1:0] LAST_WORD = IDX_W'(FRAME_WORDS - 1);

    typedef enum logic {HUNT, COLLECT} state_t;

    state_t              state_reg;
    logic [WORD_W-1:0]   sr_reg;
    logic [BIT_W-1:0]    bit_cnt_reg;
    logic [IDX_W-1:0]    word_cnt_reg;
    logic [WORD_W-1:0]   buff_reg;
    logic [IDX_W-1:0]    idx_reg;
    logic                word_valid_reg;
    logic                locked_reg;
    logic                frame_done_reg;
    logic                overrun_reg;
    logic [15:0]         sync_count_reg;
    logic [WORD_W-1:0]   shifted;

    // Value the shift register will hold once the current bit is taken in;
    // used for both the sync compare and the word load.
    assign shifted = {sr_reg[WORD_W-2:0], bit_in};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg      <= HUNT;
            sr_reg         <= '0;
            bit_cnt_reg    <= '0;
            word_cnt_reg   <= '0;
            buff_reg       <= '0;
            idx_reg        <= '0;
            word_valid_reg <= 1'b0;
            locked_reg     <= 1'b0;
            frame_done_reg <= 1'b0;
            overrun_reg    <= 1'b0;
            sync_count_reg <= '0;
        end else begin
            frame_done_reg <= 1'b0;
            if (word_valid_reg && out_ready) begin
                word_valid_reg <= 1'b0;
            end
            if (bit_valid) begin
                sr_reg <= shifted;
                case (state_reg)
                    HUNT: begin
                        if (shifted == SYNC_WORD) begin
                            state_reg    <= COLLECT;
                            locked_reg   <= 1'b1;
                            bit_cnt_reg  <= '0;
                            word_cnt_reg <= '0;
                            if (sync_count_reg != 16'hFFFF) begin
                                sync_count_reg <= sync_count_reg + 16'd1;
                            end
                        end
                    end
                    COLLECT: begin
                        if (bit_cnt_reg == LAST_BIT) begin
                            // A load overrides the consume-clear above, so a
                            // back-to-back word keeps word_valid high.
                            buff_reg       <= shifted;
                            idx_reg        <= word_cnt_reg;
                            word_valid_reg <= 1'b1;
                            bit_cnt_reg    <= '0;
                            word_cnt_reg   <= word_cnt_reg + IDX_W'(1);
                            if (word_valid_reg && !out_ready) begin
                                overrun_reg <= 1'b1;
                            end
                            if (word_cnt_reg == LAST_WORD) begin
                                frame_done_reg <= 1'b1;
                                locked_reg     <= 1'b0;
                                state_reg      <= HUNT;
                                sr_reg         <= '0;
                                word_cnt_reg   <= '0;
                            end
                        end else begin
                            bit_cnt_reg <= bit_cnt_reg + BIT_W'(1);
                        end
                    end
                    default: state_reg <= HUNT;
                endcase
            end
        end
    end

    assign buff_out   = buff_reg;
    assign word_valid = word_valid_reg;
    assign word_idx   = idx_reg;
    assign locked     = locked_reg;
    assign frame_done = frame_done_reg;
    assign overrun    = overrun_reg;
    assign sync_count = sync_count_reg;

endmodule

// File: tb/tb_rx_word_buffer.sv
// Directed bench for rx_word_buffer: sync hunt, payload packing, handshake,
// overrun and asynchronous reset, with hand-computed expectations.
module tb_rx_word_buffer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        bit_in = 1'b0;
    logic        bit_valid = 1'b0;
    logic        out_ready = 1'b1;
    logic [15:0] buff_out;
    logic        word_valid;
    logic [2:0]  word_idx;
    logic        locked;
    logic        frame_done;
    logic        overrun;
    logic [15:0] sync_count;

    int          checks = 0;
    int          failures = 0;
    logic [15:0] exp_sync = 16'd0;

    rx_word_buffer dut (
        .clk        (clk),
        .reset      (reset),
        .bit_in     (bit_in),
        .bit_valid  (bit_valid),
        .out_ready  (out_ready),
        .buff_out   (buff_out),
        .word_valid (word_valid),
        .word_idx   (word_idx),
        .locked     (locked),
        .frame_done (frame_done),
        .overrun    (overrun),
        .sync_count (sync_count)
    );

    always #5 clk = ~clk;

    // One clock: inputs applied 1 time unit after a rising edge, outputs then
    // observed 1 time unit after the next rising edge.
    task automatic send_bit(input logic b, input logic v);
        bit_in    = b;
        bit_valid = v;
        @(posedge clk);
        #1;
    endtask

    task automatic send_sync(input string tag);
        logic [15:0] s;
        s = 16'hEB90;
        for (int i = 15; i >= 1; i--) send_bit(s[i], 1'b1);
        checks++;
        if (locked !== 1'b0) begin
            failures++;
            $display("FAIL %s_prelock: locked=%b expected 0", tag, locked);
        end
        send_bit(s[0], 1'b1);
        exp_sync = exp_sync + 16'd1;
        checks++;
        if (locked !== 1'b1 || sync_count !== exp_sync) begin
            failures++;
            $display("FAIL %s_lock: locked=%b sync_count=%0d expected 1 / %0d", tag, locked, sync_count, exp_sync);
        end
        $display("txn %s sync locked=%b sync_count=%0d", tag, locked, sync_count);
    endtask

    task automatic send_payload(input logic [15:0] w, input logic [2:0] idx, input int gap,
                                input logic last, input logic exp_pre, input string tag);
        for (int i = 15; i >= 1; i--) begin
            if (i != 15) repeat (gap) send_bit(1'b0, 1'b0);
            send_bit(w[i], 1'b1);
        end
        repeat (gap) send_bit(1'b0, 1'b0);
        checks++;
        if (locked !== 1'b1 || frame_done !== 1'b0 || word_valid !== exp_pre) begin
            failures++;
            $display("FAIL %s_pre%0d: locked=%b frame_done=%b word_valid=%b expected 1/0/%b", tag, idx, locked, frame_done, word_valid, exp_pre);
        end
        send_bit(w[0], 1'b1);
        checks++;
        if (word_valid !== 1'b1 || buff_out !== w || word_idx !== idx || frame_done !== last || locked !== !last) begin
            failures++;
            $display("FAIL %s_word%0d: valid=%b data=%h idx=%0d done=%b locked=%b expected 1/%h/%0d/%b/%b",
                     tag, idx, word_valid, buff_out, word_idx, frame_done, locked, w, idx, last, !last);
        end
        $display("txn %s word idx=%0d data=%h valid=%b done=%b", tag, word_idx, buff_out, word_valid, frame_done);
    endtask

    task automatic finish_frame(input string tag);
        send_bit(1'b0, 1'b0);
        checks++;
        if (frame_done !== 1'b0 || word_valid !== 1'b0 || locked !== 1'b0 || sync_count !== exp_sync) begin
            failures++;
            $display("FAIL %s_end: done=%b valid=%b locked=%b sync_count=%0d expected 0/0/0/%0d", tag, frame_done, word_valid, locked, sync_count, exp_sync);
        end
    endtask

    task automatic run_frame(input int gap, input string tag);
        send_sync(tag);
        for (int k = 0; k < 8; k++) begin
            send_payload(16'(k + 1), 3'(k), gap, k == 7, 1'b0, tag);
        end
        finish_frame(tag);
    endtask

    task automatic test_reset;
        bit_valid = 1'b0;
        out_ready = 1'b1;
        #1 reset = 1'b0;
        #1;
        checks++;
        if ({buff_out, word_valid, word_idx, locked, frame_done, overrun, sync_count} !== '0) begin
            failures++;
            $display("FAIL reset_state: data=%h valid=%b idx=%0d locked=%b done=%b ovr=%b sc=%0d expected all 0",
                     buff_out, word_valid, word_idx, locked, frame_done, overrun, sync_count);
        end
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        $display("txn reset released");
    endtask

    task automatic test_basic;
        run_frame(0, "basic");
    endtask

    task automatic test_prefix;
        logic [12:0] pre;
        pre = 13'b1110_1011_1001_1;
        for (int i = 12; i >= 0; i--) begin
            send_bit(pre[i], 1'b1);
            checks++;
            if (locked !== 1'b0 || sync_count !== exp_sync) begin
                failures++;
                $display("FAIL prefix_nolock: locked=%b sync_count=%0d expected 0/%0d", locked, sync_count, exp_sync);
            end
        end
        run_frame(0, "prefix");
    endtask

    task automatic test_gap;
        run_frame(3, "gap");
    endtask

    task automatic test_overrun;
        out_ready = 1'b0;
        send_sync("ovr");
        send_payload(16'h0001, 3'd0, 0, 1'b0, 1'b0, "ovr");
        checks++;
        if (overrun !== 1'b0) begin
            failures++;
            $display("FAIL ovr_early: overrun=%b expected 0", overrun);
        end
        send_payload(16'h0002, 3'd1, 0, 1'b0, 1'b1, "ovr");
        send_bit(1'b0, 1'b0);
        checks++;
        if (overrun !== 1'b1 || word_valid !== 1'b1 || buff_out !== 16'h0002 || word_idx !== 3'd1) begin
            failures++;
            $display("FAIL ovr_hold: ovr=%b valid=%b data=%h idx=%0d expected 1/1/0002/1", overrun, word_valid, buff_out, word_idx);
        end
        out_ready = 1'b1;
        send_bit(1'b0, 1'b0);
        checks++;
        if (overrun !== 1'b1 || word_valid !== 1'b0) begin
            failures++;
            $display("FAIL ovr_consume: ovr=%b valid=%b expected 1/0", overrun, word_valid);
        end
        for (int k = 2; k < 8; k++) begin
            send_payload(16'(k + 1), 3'(k), 0, k == 7, 1'b0, "ovr");
        end
        finish_frame("ovr");
        checks++;
        if (overrun !== 1'b1) begin
            failures++;
            $display("FAIL ovr_sticky: overrun=%b expected 1", overrun);
        end
    endtask

    task automatic test_reset_mid;
        logic [15:0] w;
        w = 16'h0002;
        out_ready = 1'b0;
        send_sync("rmid");
        send_payload(16'h0001, 3'd0, 0, 1'b0, 1'b0, "rmid");
        for (int i = 15; i >= 12; i--) send_bit(w[i], 1'b1);
        #3 reset = 1'b0;
        #1;
        checks++;
        if ({buff_out, word_valid, word_idx, locked, frame_done, overrun, sync_count} !== '0) begin
            failures++;
            $display("FAIL rmid_async: data=%h valid=%b idx=%0d locked=%b done=%b ovr=%b sc=%0d expected all 0",
                     buff_out, word_valid, word_idx, locked, frame_done, overrun, sync_count);
        end
        exp_sync = 16'd0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        out_ready = 1'b1;
        run_frame(0, "rmid");
    endtask

    task automatic test_payload_sync;
        send_sync("psync");
        for (int k = 0; k < 8; k++) begin
            send_payload((k == 3) ? 16'hEB90 : 16'(k + 1), 3'(k), 0, k == 7, 1'b0, "psync");
        end
        finish_frame("psync");
    endtask

    initial begin
        test_reset();
        test_basic();
        test_prefix();
        test_gap();
        test_overrun();
        test_reset_mid();
        test_payload_sync();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
